// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit SLL/SRA/ROR shifter between two requesters.
// The result of the accepted request is registered and returned one cycle later.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req0_valid,
    input  logic [1:0]  req0_mode,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_mode,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    logic        r_prio;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    mode_e       w_mode;
    logic [15:0] w_data;
    logic [3:0]  w_amt;
    logic [31:0] w_rot;
    logic [15:0] w_result;

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign w_gnt0    = rst_n & en & req0_valid & (~req1_valid | ~r_prio);
    assign w_gnt1    = rst_n & en & req1_valid & (~req0_valid |  r_prio);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_mode = mode_e'(w_gnt1 ? req1_mode : req0_mode);
    assign w_data = w_gnt1 ? req1_data : req0_data;
    assign w_amt  = w_gnt1 ? req1_amt  : req0_amt;
    assign w_rot  = {w_data, w_data} >> w_amt;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves w_result unassigned (no latch).
        w_result = 16'h0000;
        case (w_mode)
            MODE_SLL: w_result = w_data << w_amt;
            MODE_SRA: w_result = 16'($signed(w_data) >>> w_amt);
            MODE_ROR: w_result = w_rot[15:0];
            default:  w_result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= 16'h0000;
            r_rsp_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rsp0_valid <= w_gnt0;
            r_rsp1_valid <= w_gnt1;
            r_rsp_err    <= w_any_gnt & (w_mode == MODE_RSV);
            if (w_any_gnt) begin
                r_rsp_data <= w_result;
                r_prio     <= w_gnt0;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

endmodule
